traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter CNT_W, default 8, width of the completed-cycle counter.
REQ-002 Parameter MAX_DWELL, default 8, maximum legal consecutive cycles in one colour (used only with TLM_DWELL_CHECK_EN).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 red / yellow / green  input  1 each  observed lamp drives, sampled every rising edge.
REQ-007 err_clr  input  1  clears err_sticky.
REQ-008 phase  output  2  tracked phase: 00 idle/unlocked, 01 green, 10 yellow, 11 red.
REQ-009 cycle_count  output  CNT_W  completed red->green cycles, modulo 2^CNT_W.
REQ-010 seq_err / multi_err / dark_err / dwell_err  output  1 each  single-cycle error pulses.
REQ-011 err_sticky  output  1  latched OR of all error pulses.

Function
REQ-012 All outputs SHALL be registered; each output reflects the lamp sample taken on that same rising edge (one-cycle latency from input change).
REQ-013 Decode per sample: exactly one lamp high = valid colour; none high = dark; two or more high = multi.
REQ-014 IDLE: dark keeps IDLE with no error; valid colour locks phase to that colour, no seq_err; multi pulses multi_err and stays IDLE.
REQ-015 Locked phase: same colour holds phase and increments dwell (saturating).
REQ-016 Legal advance is green->yellow, yellow->red, red->green; phase advances and dwell restarts at 1.
REQ-017 Any other valid colour change SHALL pulse seq_err and resync phase to the observed colour, dwell = 1.
REQ-018 Locked + dark SHALL pulse dark_err and return to IDLE; locked + multi SHALL pulse multi_err and return to IDLE.
REQ-019 cycle_count SHALL increment only on a legal red->green advance, wrapping from 2^CNT_W-1 to 0.
REQ-020 Error pulses last exactly one cycle unless the error condition recurs next sample.
REQ-021 err_sticky SHALL set on any error pulse and clear on err_clr; simultaneous set and clear leaves err_sticky = 1.

Reset
REQ-022 While reset is high at an edge: phase = 00, cycle_count = 0, dwell = 0, all pulses = 0, err_sticky = 0; lamp inputs ignored.
REQ-023 Reset mid-operation SHALL abandon the tracked phase; first post-reset sample is treated as in IDLE.

Configuration
REQ-024 Macro TLM_DWELL_CHECK_EN defined: dwell counter present, width ceil(log2(MAX_DWELL+2)), dwell_err pulses once on the sample that makes dwell equal MAX_DWELL+1, counter then saturates with no further pulse until the phase changes.
REQ-025 Macro TLM_DWELL_CHECK_EN undefined: no dwell counter, dwell_err tied 0, all other behaviour identical.

Verification
REQ-026 Reset, then dark,G,Y,R,G one cycle each -> phase 00,01,10,11,01; cycle_count 0->1 on final sample; no error pulses; err_sticky = 0.
REQ-027 Locked green, then red -> seq_err high one cycle, phase = 11, err_sticky = 1; cycle_count unchanged.
REQ-028 Locked yellow, then red+green together -> multi_err one cycle, phase = 00; following green -> phase 01, no seq_err.
REQ-029 TLM_DWELL_CHECK_EN, MAX_DWELL = 4, green held 7 samples -> dwell_err high only on 5th sample; phase stays 01.
REQ-030 CNT_W = 2, four full G,Y,R cycles then G -> cycle_count 1,2,3,0; err_clr asserted on same edge as a dark_err -> err_sticky remains 1.
REQ-031 Phase red with cycle_count = 3, reset asserted one edge -> all outputs 0; next sample yellow -> phase 10, no seq_err.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Traffic-light lamp monitor: tracks the G->Y->R phase, counts completed cycles and flags sequencing faults.
// Optional dwell-time checking is enabled by defining TLM_DWELL_CHECK_EN.
module traffic_light_monitor #(
  parameter int CNT_W     = 8,
  parameter int MAX_DWELL = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             err_clr,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] cycle_count,
  output logic             seq_err,
  output logic             multi_err,
  output logic             dark_err,
  output logic             dwell_err,
  output logic             err_sticky
);

  // state     | meaning
  // PH_IDLE   | unlocked, waiting for a single valid lamp
  // PH_GREEN  | locked on green
  // PH_YELLOW | locked on yellow
  // PH_RED    | locked on red
  localparam logic [1:0] PH_IDLE   = 2'b00;
  localparam logic [1:0] PH_GREEN  = 2'b01;
  localparam logic [1:0] PH_YELLOW = 2'b10;
  localparam logic [1:0] PH_RED    = 2'b11;

  function automatic logic [1:0] legal_next(input logic [1:0] p);
    case (p)
      PH_GREEN:  legal_next = PH_YELLOW;
      PH_YELLOW: legal_next = PH_RED;
      PH_RED:    legal_next = PH_GREEN;
      default:   legal_next = PH_IDLE;
    endcase
  endfunction

  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seq_q, seq_d;
  logic             multi_q, multi_d;
  logic             dark_q, dark_d;
  logic             dwell_err_q, dwell_err_d;
  logic             sticky_q, sticky_d;

  logic       lamp_single, lamp_dark, lamp_multi, hold;
  logic [1:0] obs;

  assign lamp_dark   = ~(red | yellow | green);
  assign lamp_single = (red ^ yellow ^ green) & ~(red & yellow & green);
  assign lamp_multi  = ~lamp_dark & ~lamp_single;
  assign obs         = green ? PH_GREEN : (yellow ? PH_YELLOW : PH_RED);
  assign hold        = lamp_single & (phase_q != PH_IDLE) & (obs == phase_q);

`ifdef TLM_DWELL_CHECK_EN
  localparam int              DW_W   = $clog2(MAX_DWELL + 2);
  localparam logic [DW_W-1:0] DW_LIM = DW_W'(MAX_DWELL + 1);
  logic [DW_W-1:0] dwell_q, dwell_d;
`endif

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q     <= PH_IDLE;
      cnt_q       <= '0;
      seq_q       <= 1'b0;
      multi_q     <= 1'b0;
      dark_q      <= 1'b0;
      dwell_err_q <= 1'b0;
      sticky_q    <= 1'b0;
`ifdef TLM_DWELL_CHECK_EN
      dwell_q     <= '0;
`endif
    end else begin
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      multi_q     <= multi_d;
      dark_q      <= dark_d;
      dwell_err_q <= dwell_err_d;
      sticky_q    <= sticky_d;
`ifdef TLM_DWELL_CHECK_EN
      dwell_q     <= dwell_d;
`endif
    end
  end

  // next-state
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    seq_d   = 1'b0;
    multi_d = 1'b0;
    dark_d  = 1'b0;
    if (lamp_multi) begin
      multi_d = 1'b1;
      phase_d = PH_IDLE;
    end else if (lamp_dark) begin
      dark_d  = (phase_q != PH_IDLE);
      phase_d = PH_IDLE;
    end else if (phase_q == PH_IDLE) begin
      phase_d = obs;
    end else if (!hold) begin
      // any colour change resyncs to the observed lamp; only the legal step is error-free
      phase_d = obs;
      if (obs != legal_next(phase_q)) begin
        seq_d = 1'b1;
      end else if (phase_q == PH_RED) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef TLM_DWELL_CHECK_EN
  // dwell saturates at DW_LIM so the overrun pulse fires only once per phase
  always_comb begin
    if (phase_d == PH_IDLE) begin
      dwell_d = '0;
    end else if (hold) begin
      dwell_d = (dwell_q == DW_LIM) ? dwell_q : dwell_q + DW_W'(1);
    end else begin
      dwell_d = DW_W'(1);
    end
    dwell_err_d = (dwell_d == DW_LIM) && !(hold && (dwell_q == DW_LIM));
  end
`else
  // dwell checking compiled out; MAX_DWELL has no effect in this build
  assign dwell_err_d = (MAX_DWELL < 0);
`endif

  assign sticky_d = seq_d | multi_d | dark_d | dwell_err_d | (sticky_q & ~err_clr);

  // outputs
  always_comb begin
    phase       = phase_q;
    cycle_count = cnt_q;
    seq_err     = seq_q;
    multi_err   = multi_q;
    dark_err    = dark_q;
    dwell_err   = dwell_err_q;
    err_sticky  = sticky_q;
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed vector table, corner sequences,
// and randomized lamp traffic against a run-length reference model.
module tb_traffic_light_monitor;

  localparam int CNT_W     = 2;
  localparam int MAX_DWELL = 4;
`ifdef TLM_DWELL_CHECK_EN
  localparam bit DWELL_ON = 1'b1;
`else
  localparam bit DWELL_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, red, yellow, green, err_clr;
  logic [1:0]       phase;
  logic [CNT_W-1:0] cycle_count;
  logic seq_err, multi_err, dark_err, dwell_err, err_sticky;

  traffic_light_monitor #(.CNT_W(CNT_W), .MAX_DWELL(MAX_DWELL)) dut (
    .clock(clock), .reset(reset), .red(red), .yellow(yellow), .green(green),
    .err_clr(err_clr), .phase(phase), .cycle_count(cycle_count),
    .seq_err(seq_err), .multi_err(multi_err), .dark_err(dark_err),
    .dwell_err(dwell_err), .err_sticky(err_sticky)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: colour 0 idle, 1 green, 2 yellow, 3 red
  int m_col, m_cnt, m_run;
  bit m_seq, m_multi, m_dark, m_dwell, m_sticky;
  int succ_tbl[4] = '{0, 2, 3, 1};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit r, input bit y, input bit g, input bit clr);
    int n, c;
    if (rst) begin
      m_col = 0; m_cnt = 0; m_run = 0;
      m_seq = 0; m_multi = 0; m_dark = 0; m_dwell = 0; m_sticky = 0;
      return;
    end
    n = int'(r) + int'(y) + int'(g);
    c = g ? 1 : (y ? 2 : 3);
    m_seq = 0; m_multi = 0; m_dark = 0; m_dwell = 0;
    if (n >= 2) begin
      m_multi = 1; m_col = 0; m_run = 0;
    end else if (n == 0) begin
      m_dark = (m_col != 0); m_col = 0; m_run = 0;
    end else if (m_col == 0) begin
      m_col = c; m_run = 1;
    end else if (c == m_col) begin
      m_run++;
    end else begin
      if (c != succ_tbl[m_col]) m_seq = 1;
      else if (m_col == 3) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      m_col = c; m_run = 1;
    end
    if (DWELL_ON && n == 1 && m_run == MAX_DWELL + 1) m_dwell = 1;
    m_sticky = m_seq | m_multi | m_dark | m_dwell | (m_sticky & !clr);
  endtask

  task automatic apply(input bit rst, input bit r, input bit y, input bit g, input bit clr);
    reset = rst; red = r; yellow = y; green = g; err_clr = clr;
    @(posedge clock);
    #1;
    model_step(rst, r, y, g, clr);
  endtask

  task automatic check_model();
    chk("phase", int'(phase), m_col);
    chk("cycle_count", int'(cycle_count), m_cnt);
    chk("seq_err", int'(seq_err), int'(m_seq));
    chk("multi_err", int'(multi_err), int'(m_multi));
    chk("dark_err", int'(dark_err), int'(m_dark));
    chk("dwell_err", int'(dwell_err), int'(m_dwell));
    chk("err_sticky", int'(err_sticky), int'(m_sticky));
  endtask

  typedef struct {
    bit rst, r, y, g, clr;
    int ph, cnt;
    bit seq, multi, dark, sticky;
  } vec_t;

  vec_t vt[16];

  initial begin
    reset = 1'b1; red = 0; yellow = 0; green = 0; err_clr = 0;
    //          rst r y g clr  ph cnt seq mul drk stk
    vt[0]  = '{1, 0,0,0, 0,  0, 0,  0, 0, 0, 0};
    vt[1]  = '{0, 0,0,0, 0,  0, 0,  0, 0, 0, 0};
    vt[2]  = '{0, 0,0,1, 0,  1, 0,  0, 0, 0, 0};
    vt[3]  = '{0, 0,1,0, 0,  2, 0,  0, 0, 0, 0};
    vt[4]  = '{0, 1,0,0, 0,  3, 0,  0, 0, 0, 0};
    vt[5]  = '{0, 0,0,1, 0,  1, 1,  0, 0, 0, 0};
    vt[6]  = '{0, 1,0,0, 0,  3, 1,  1, 0, 0, 1};
    vt[7]  = '{0, 1,0,0, 0,  3, 1,  0, 0, 0, 1};
    vt[8]  = '{0, 1,0,0, 1,  3, 1,  0, 0, 0, 0};
    vt[9]  = '{0, 0,0,1, 0,  1, 2,  0, 0, 0, 0};
    vt[10] = '{0, 0,1,0, 0,  2, 2,  0, 0, 0, 0};
    vt[11] = '{0, 1,0,1, 0,  0, 2,  0, 1, 0, 1};
    vt[12] = '{0, 0,0,1, 0,  1, 2,  0, 0, 0, 1};
    vt[13] = '{0, 0,0,1, 1,  1, 2,  0, 0, 0, 0};
    vt[14] = '{0, 0,0,0, 0,  0, 2,  0, 0, 1, 1};
    vt[15] = '{0, 0,0,0, 1,  0, 2,  0, 0, 0, 0};

    foreach (vt[i]) begin
      apply(vt[i].rst, vt[i].r, vt[i].y, vt[i].g, vt[i].clr);
      chk($sformatf("vec%0d phase", i), int'(phase), vt[i].ph);
      chk($sformatf("vec%0d cycle_count", i), int'(cycle_count), vt[i].cnt);
      chk($sformatf("vec%0d seq_err", i), int'(seq_err), int'(vt[i].seq));
      chk($sformatf("vec%0d multi_err", i), int'(multi_err), int'(vt[i].multi));
      chk($sformatf("vec%0d dark_err", i), int'(dark_err), int'(vt[i].dark));
      chk($sformatf("vec%0d dwell_err", i), int'(dwell_err), 0);
      chk($sformatf("vec%0d err_sticky", i), int'(err_sticky), int'(vt[i].sticky));
    end

    // counter wrap, then err_clr colliding with a dark_err
    apply(1, 0,0,0, 0);
    apply(0, 0,0,1, 0);
    for (int k = 1; k <= 4; k++) begin
      apply(0, 0,1,0, 0);
      apply(0, 1,0,0, 0);
      apply(0, 0,0,1, 0);
      chk($sformatf("wrap cycle_count k=%0d", k), int'(cycle_count), k % 4);
    end
    apply(0, 0,0,0, 1);
    chk("dark+clr dark_err", int'(dark_err), 1);
    chk("dark+clr err_sticky", int'(err_sticky), 1);

    // reset from red with count 3, then resume on yellow as from idle
    apply(1, 0,0,0, 0);
    for (int k = 0; k < 4; k++) begin
      apply(0, 0,0,1, 0);
      apply(0, 0,1,0, 0);
      apply(0, 1,0,0, 0);
    end
    chk("pre-reset phase", int'(phase), 3);
    chk("pre-reset cycle_count", int'(cycle_count), 3);
    apply(1, 1,0,0, 0);
    chk("midreset phase", int'(phase), 0);
    chk("midreset cycle_count", int'(cycle_count), 0);
    chk("midreset errs", int'({seq_err, multi_err, dark_err, dwell_err, err_sticky}), 0);
    apply(0, 0,1,0, 0);
    chk("post-reset phase", int'(phase), 2);
    chk("post-reset seq_err", int'(seq_err), 0);

    // green held 7 samples: dwell overrun only on the 5th when checking is built in
    apply(1, 0,0,0, 0);
    for (int i = 0; i < 7; i++) begin
      apply(0, 0,0,1, 0);
      chk($sformatf("dwell sample%0d dwell_err", i + 1), int'(dwell_err), int'(DWELL_ON && i == 4));
      chk($sformatf("dwell sample%0d phase", i + 1), int'(phase), 1);
    end
    check_model();

    // randomized traffic against the model
    for (int t = 0; t < 3000; t++) begin
      bit rst, clr, r, y, g;
      int sel, c;
      rst = ($urandom_range(0, 63) == 0);
      clr = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 11);
      if (sel <= 4)      c = (m_col == 0) ? $urandom_range(1, 3) : succ_tbl[m_col];
      else if (sel <= 8) c = (m_col == 0) ? 1 : m_col;
      else if (sel == 9) c = $urandom_range(1, 3);
      else               c = 0;
      r = (c == 3); y = (c == 2); g = (c == 1);
      if (sel == 11) {r, y, g} = 3'($urandom_range(3, 7)) | 3'b011;
      apply(rst, r, y, g, clr);
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
